// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and address decode for the data-memory responder
//
// Purpose : FSM state encoding and the byte-address decode used by
//           data_mem_responder (offset from base, alignment and range check).
// Contents: dmemState_e   - IDLE / WAIT / RESP
//           dmemDecode_t  - word index plus error flag
//           decodeAddr()  - turns a byte address into a word index and error flag
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmemState_e;

  typedef struct packed {
    logic [29:0] wordIdx;
    logic        err;
  } dmemDecode_t;

  // The subtraction wraps on purpose: an address below the base lands at a
  // huge offset and is rejected by the range check.
  function automatic dmemDecode_t decodeAddr(input logic [31:0] addr,
                                             input logic [31:0] baseAddr,
                                             input logic [31:0] depthWords);
    logic [31:0] off;
    dmemDecode_t dec;
    off         = addr - baseAddr;
    dec.wordIdx = off[31:2];
    dec.err     = (off[1:0] != 2'b00) || ({2'b00, off[31:2]} >= depthWords);
    return dec;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// rtl/dmem_sram.sv - single-port synchronous word array with byte-lane write enables
//
// Purpose : Storage for the data-memory responder. One access per enabled
//           cycle: a write updates the selected byte lanes, a read loads the
//           output register. The output register only changes on a read, so
//           it holds the last read word until the next one. No reset.
// Ports   : CLK   in  1   clock
//           en    in  1   access enable
//           we    in  1   1 = write, 0 = read (when en)
//           be    in  4   byte-lane write enables, lane 0 = bits 7:0
//           addr  in  AW  word address
//           wdata in  32  write data
//           rdata out 32  registered read data
module dmem_sram #(
  parameter int DEPTH_WORDS = 512,
  parameter int AW          = 9
) (
  input  logic          CLK,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge CLK) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - MEM-stage data port responder with fixed latency
//
// Purpose : Accepts one load/store at a time while idle, services it against
//           dmem_sram at the accept edge and presents a one-cycle response
//           LATENCY cycles later. Optional byte strobes are enabled by
//           defining DMEM_BYTE_STROBE_EN (adds req_be).
// Ports   : CLK        in  1   clock
//           RESET      in  1   synchronous active-high reset
//           req_be     in  4   store byte lanes (DMEM_BYTE_STROBE_EN only)
//           req_valid  in  1   request present
//           req_write  in  1   1 = store, 0 = load
//           req_addr   in  32  byte address
//           req_wdata  in  32  store data
//           req_ready  out 1   high in IDLE only
//           resp_valid out 1   one-cycle response strobe
//           resp_rdata out 32  load data, 0 for stores/errors/idle
//           resp_err   out 1   misaligned or out-of-range access
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 512,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        CLK,
  input  logic        RESET,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]  req_be,
`endif
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

  dmemState_e  state, stateNext;
  logic [CW-1:0] latCnt, latCntNext;
  logic        capWrite, capErr;
  dmemDecode_t dec;
  logic        accept;
  logic [3:0]  laneEn;
  logic [31:0] sramRdata;
  logic        unusedIdxBits;

  assign dec           = decodeAddr(req_addr, BASE_ADDR, 32'(DEPTH_WORDS));
  assign unusedIdxBits = ^dec.wordIdx;
  // Reset wins over an accept in the same cycle, including the array write.
  assign accept        = req_valid && (state == IDLE) && !RESET;

`ifdef DMEM_BYTE_STROBE_EN
  assign laneEn = req_be;
`else
  assign laneEn = 4'hF;
`endif

  // Loads read at the accept edge; the SRAM output register holds the word
  // until RESP because nothing else reads the array in between.
  dmem_sram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_sram (
    .CLK  (CLK),
    .en   (accept),
    .we   (accept && req_write && !dec.err),
    .be   (laneEn),
    .addr (dec.wordIdx[AW-1:0]),
    .wdata(req_wdata),
    .rdata(sramRdata)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      latCnt   <= '0;
      capWrite <= 1'b0;
      capErr   <= 1'b0;
    end else begin
      state  <= stateNext;
      latCnt <= latCntNext;
      if (accept) begin
        capWrite <= req_write;
        capErr   <= dec.err;
      end
    end
  end

  always_comb begin
    stateNext  = state;
    latCntNext = latCnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY > 1) begin
            stateNext  = WAIT;
            latCntNext = CNT_LOAD;
          end else begin
            stateNext = RESP;
          end
        end
      end
      WAIT: begin
        if (latCnt == '0) begin
          stateNext = RESP;
        end else begin
          latCntNext = latCnt - CW'(1);
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid && capErr;
  assign resp_rdata = (resp_valid && !capWrite && !capErr) ? sramRdata : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed table-driven bench for data_mem_responder
module tb_data_mem_responder;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqWrite = 1'b0;
  logic [31:0] reqAddr = 32'h0;
  logic [31:0] reqWdata = 32'h0;
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]  reqBe = 4'hF;
`endif

  logic        ready0, valid0, err0;
  logic [31:0] rdata0;
  logic        ready1, valid1, err1;
  logic [31:0] rdata1;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  // Main instance: 512 words, latency 2, base 0.
  data_mem_responder #(.DEPTH_WORDS(512), .LATENCY(2), .BASE_ADDR(32'h0)) dut0 (
    .CLK       (CLK),
    .RESET     (RESET),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be    (reqBe),
`endif
    .req_valid (reqValid),
    .req_write (reqWrite),
    .req_addr  (reqAddr),
    .req_wdata (reqWdata),
    .req_ready (ready0),
    .resp_valid(valid0),
    .resp_rdata(rdata0),
    .resp_err  (err0)
  );

  // Second instance: 16 words, latency 1, base 0x1000.
  data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(1), .BASE_ADDR(32'h1000)) dut1 (
    .CLK       (CLK),
    .RESET     (RESET),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be    (reqBe),
`endif
    .req_valid (reqValid),
    .req_write (reqWrite),
    .req_addr  (reqAddr),
    .req_wdata (reqWdata),
    .req_ready (ready1),
    .resp_valid(valid1),
    .resp_rdata(rdata1),
    .resp_err  (err1)
  );

  typedef struct {
    int          sel;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] expD;
    logic        expE;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int sel, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] be,
                              input logic [31:0] expD, input logic expE);
    vec_t v;
    v.sel = sel; v.w = w; v.a = a; v.d = d; v.be = be; v.expD = expD; v.expE = expE;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic doTxn(input string tag, input int sel, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       input logic [31:0] expD, input logic expE);
    int          lat = 0;
    int          nValid = 0;
    int          expLat;
    int          k = 0;
    logic [31:0] gotD = 32'h0;
    logic        gotE = 1'b0;
    logic        readyAfter = 1'b0;
    expLat = (sel != 0) ? 1 : 2;
    @(negedge CLK);
    while (!((sel != 0) ? ready1 : ready0) && k < 20) begin
      @(negedge CLK);
      k++;
    end
    check32({tag, " ready"}, 32'((sel != 0) ? ready1 : ready0), 32'd1);
    reqValid = 1'b1;
    reqWrite = w;
    reqAddr  = a;
    reqWdata = d;
`ifdef DMEM_BYTE_STROBE_EN
    reqBe    = be;
`endif
    @(posedge CLK);
    #1;
    reqValid = 1'b0;
    reqWrite = ~w;
    reqAddr  = ~a;
    reqWdata = ~d;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      if ((sel != 0) ? valid1 : valid0) begin
        nValid++;
        if (lat == 0) begin
          lat  = i;
          gotD = (sel != 0) ? rdata1 : rdata0;
          gotE = (sel != 0) ? err1 : err0;
        end
      end else begin
        check32({tag, " idle rdata"}, (sel != 0) ? rdata1 : rdata0, 32'h0);
        check32({tag, " idle err"}, 32'((sel != 0) ? err1 : err0), 32'd0);
      end
      if (i == expLat + 1) readyAfter = (sel != 0) ? ready1 : ready0;
    end
    check32({tag, " latency"}, 32'(lat), 32'(expLat));
    check32({tag, " valid count"}, 32'(nValid), 32'd1);
    check32({tag, " rdata"}, gotD, expD);
    check32({tag, " err"}, 32'(gotE), 32'(expE));
    check32({tag, " ready after resp"}, 32'(readyAfter), 32'd1);
    reqWrite = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Reset state
    RESET = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    check32("reset ready0", 32'(ready0), 32'd1);
    check32("reset valid0", 32'(valid0), 32'd0);
    check32("reset rdata0", rdata0, 32'h0);
    check32("reset err0", 32'(err0), 32'd0);
    check32("reset ready1", 32'(ready1), 32'd1);
    check32("reset valid1", 32'(valid1), 32'd0);
    RESET = 1'b0;

    vecs.push_back(mk(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0));
    vecs.push_back(mk(0, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0));
    vecs.push_back(mk(0, 1'b0, 32'h0000_0013, 32'h0,         4'hF, 32'h0, 1'b1));
    vecs.push_back(mk(0, 1'b0, 32'h0000_0800, 32'h0,         4'hF, 32'h0, 1'b1));
    vecs.push_back(mk(0, 1'b1, 32'h0000_0011, 32'h9999_9999, 4'hF, 32'h0, 1'b1));
    vecs.push_back(mk(0, 1'b1, 32'h0000_0800, 32'h7777_7777, 4'hF, 32'h0, 1'b1));
    vecs.push_back(mk(0, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0));
    vecs.push_back(mk(0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0));
    vecs.push_back(mk(0, 1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'h0BAD_F00D, 1'b0));
    vecs.push_back(mk(0, 1'b1, 32'h0000_07FC, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0));
    vecs.push_back(mk(0, 1'b0, 32'h0000_07FC, 32'h0,         4'hF, 32'hA5A5_A5A5, 1'b0));
    vecs.push_back(mk(0, 1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF, 32'h0, 1'b0));
    vecs.push_back(mk(0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0));
    vecs.push_back(mk(0, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, 32'h0, 1'b1));
    foreach (vecs[i]) begin
      doTxn($sformatf("v%0d", i), vecs[i].sel, vecs[i].w, vecs[i].a, vecs[i].d,
            vecs[i].be, vecs[i].expD, vecs[i].expE);
    end

    // Request held through WAIT/RESP with a different store must be ignored.
    @(negedge CLK);
    reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'h10; reqWdata = 32'h0;
    @(posedge CLK);
    #1;
    reqWrite = 1'b1; reqAddr = 32'h40; reqWdata = 32'h5555_5555;
    @(negedge CLK);
    check32("hold n1 ready", 32'(ready0), 32'd0);
    check32("hold n1 valid", 32'(valid0), 32'd0);
    @(negedge CLK);
    check32("hold n2 valid", 32'(valid0), 32'd1);
    check32("hold n2 rdata", rdata0, 32'hDEAD_BEEF);
    check32("hold n2 ready", 32'(ready0), 32'd0);
    @(negedge CLK);
    check32("hold n3 ready", 32'(ready0), 32'd1);
    check32("hold n3 valid", 32'(valid0), 32'd0);
    reqValid = 1'b0; reqWrite = 1'b0;
    doTxn("hold reload", 0, 1'b0, 32'h40, 32'h0, 4'hF, 32'h1234_5678, 1'b0);

    // Reset during WAIT aborts the load without a response.
    @(negedge CLK);
    reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'h24;
    @(posedge CLK);
    #1;
    reqValid = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    check32("abort n1 valid", 32'(valid0), 32'd0);
    @(negedge CLK);
    check32("abort n2 valid", 32'(valid0), 32'd0);
    check32("abort n2 ready", 32'(ready0), 32'd1);
    RESET = 1'b0;
    @(negedge CLK);
    check32("abort n3 valid", 32'(valid0), 32'd0);
    check32("abort n3 rdata", rdata0, 32'h0);
    doTxn("abort survive", 0, 1'b0, 32'h20, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0);

    // Latency-1 instance with a non-zero base.
    vecs.delete();
    vecs.push_back(mk(1, 1'b1, 32'h0000_1008, 32'h600D_CAFE, 4'hF, 32'h0, 1'b0));
    vecs.push_back(mk(1, 1'b0, 32'h0000_1008, 32'h0,         4'hF, 32'h600D_CAFE, 1'b0));
    vecs.push_back(mk(1, 1'b0, 32'h0000_0FFC, 32'h0,         4'hF, 32'h0, 1'b1));
    vecs.push_back(mk(1, 1'b0, 32'h0000_1040, 32'h0,         4'hF, 32'h0, 1'b1));
    vecs.push_back(mk(1, 1'b1, 32'h0000_103C, 32'h1357_9BDF, 4'hF, 32'h0, 1'b0));
    vecs.push_back(mk(1, 1'b0, 32'h0000_103C, 32'h0,         4'hF, 32'h1357_9BDF, 1'b0));
`ifdef DMEM_BYTE_STROBE_EN
    vecs.push_back(mk(0, 1'b1, 32'h0000_0030, 32'h1122_3344, 4'hF, 32'h0, 1'b0));
    vecs.push_back(mk(0, 1'b1, 32'h0000_0030, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0));
    vecs.push_back(mk(0, 1'b0, 32'h0000_0030, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0));
    vecs.push_back(mk(0, 1'b1, 32'h0000_0030, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0));
    vecs.push_back(mk(0, 1'b0, 32'h0000_0030, 32'h0,         4'hF, 32'h11BB_33DD, 1'b0));
    vecs.push_back(mk(1, 1'b1, 32'h0000_1010, 32'hAABB_CCDD, 4'hF, 32'h0, 1'b0));
    vecs.push_back(mk(1, 1'b1, 32'h0000_1010, 32'h0102_0304, 4'hA, 32'h0, 1'b0));
    vecs.push_back(mk(1, 1'b0, 32'h0000_1010, 32'h0,         4'hF, 32'h01BB_03DD, 1'b0));
`endif
    foreach (vecs[i]) begin
      doTxn($sformatf("w%0d", i), vecs[i].sel, vecs[i].w, vecs[i].a, vecs[i].d,
            vecs[i].be, vecs[i].expD, vecs[i].expE);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
